// File: rtl/verify_report_uart_tx.sv
// Result-link transmitter: snapshots the total/correct counters and sends a 10-byte UART 8N1 frame.
// Optional PERIODIC_REPORT_EN adds a free-running auto-report tick OR-ed with the report port.
module verify_report_uart_tx #(
  parameter int CLK_DIV       = 868,
  parameter int REPORT_PERIOD = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total,
  input  logic [31:0] correct,
  input  logic        report,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int              CW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [7:0]      HEADER    = 8'hA5;
  localparam logic [3:0]      LAST_BYTE = 4'd9;
  localparam logic [2:0]      LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  if (CLK_DIV < 2 || REPORT_PERIOD < 2) begin : g_param_check
    $error("verify_report_uart_tx: CLK_DIV and REPORT_PERIOD must be >= 2");
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [3:0]    byte_idx, byte_n;
  logic [63:0]   shadow;
  logic [7:0]    chk;
  logic [7:0]    cur_byte;
  logic          req;
  logic          capture;
  logic          done_n;
  logic          tx_n;
  logic          wrap;

`ifdef PERIODIC_REPORT_EN
  localparam int            PW          = (REPORT_PERIOD > 2) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(REPORT_PERIOD - 1);

  logic [PW-1:0] period_cnt;
  logic          tick;

  // Free-running; a tick that lands while busy is simply lost and retried next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  assign tick = (period_cnt == PERIOD_LAST);
  assign req  = report | tick;
`else
  assign req = report;
`endif

  assign chk = shadow[63:56] ^ shadow[55:48] ^ shadow[47:40] ^ shadow[39:32] ^
               shadow[31:24] ^ shadow[23:16] ^ shadow[15:8]  ^ shadow[7:0];

  assign wrap = (cnt == DIV_LAST);

  always_comb begin
    cur_byte = HEADER;
    case (byte_n)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = shadow[63:56];
      4'd2:    cur_byte = shadow[55:48];
      4'd3:    cur_byte = shadow[47:40];
      4'd4:    cur_byte = shadow[39:32];
      4'd5:    cur_byte = shadow[31:24];
      4'd6:    cur_byte = shadow[23:16];
      4'd7:    cur_byte = shadow[15:8];
      4'd8:    cur_byte = shadow[7:0];
      4'd9:    cur_byte = chk;
      default: cur_byte = HEADER;
    endcase
  end

  // frame_done gates acceptance so a request in the completion cycle is dropped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    capture = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        bit_n  = '0;
        byte_n = '0;
        if (req && !frame_done) begin
          state_n = START;
          capture = 1'b1;
        end
      end
      START: begin
        if (wrap) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_n = '0;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (wrap) begin
          cnt_n = '0;
          if (byte_idx == LAST_BYTE) begin
            state_n = IDLE;
            byte_n  = '0;
            done_n  = 1'b1;
          end else begin
            state_n = START;
            byte_n  = byte_idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx comes straight from a flop.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shadow     <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      byte_idx   <= byte_n;
      if (capture) begin
        shadow <= {total, correct};
      end
      tx         <= tx_n;
      busy       <= (state_n != IDLE);
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_verify_report_uart_tx.sv
// Directed bench for verify_report_uart_tx (CLK_DIV=4): decodes whole frames from tx and
// compares them with hand-computed byte sequences.
module tb_verify_report_uart_tx;

  localparam int CLK_DIV      = 4;
  localparam int FRAME_CYCLES = 100 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        report = 1'b0;
  logic [31:0] total = '0;
  logic [31:0] correct = '0;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int          n_compared = 0;
  int          n_mismatched = 0;

  logic [79:0] frame_bytes;
  int          busy_cycles;
  int          done_pulses;
  logic        frame_ok;
  logic        tx_s [FRAME_CYCLES];

  verify_report_uart_tx #(
    .CLK_DIV      (CLK_DIV),
    .REPORT_PERIOD(1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .total     (total),
    .correct   (correct),
    .report    (report),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Request held for exactly one sampling edge; returns #1 after that edge.
  task automatic pulse_report();
    report = 1'b1;
    @(posedge clk);
    #1;
    report = 1'b0;
  endtask

  // Records len cycles starting in the cycle after the accepting edge, then decodes the frame.
  task automatic collect(input int len, input int report_at, input logic chg_en,
                         input logic [31:0] chg_total, input logic [31:0] chg_correct);
    busy_cycles = 0;
    done_pulses = 0;
    frame_ok    = 1'b1;
    frame_bytes = '0;
    for (int c = 0; c < len; c++) begin
      if (busy === 1'b1) busy_cycles++;
      if (frame_done === 1'b1) done_pulses++;
      if (c < FRAME_CYCLES) tx_s[c] = tx;
      if (c == 0 && chg_en) begin
        total   = chg_total;
        correct = chg_correct;
      end
      report = (c == report_at);
      @(posedge clk);
      #1;
    end
    report = 1'b0;
    if (len >= FRAME_CYCLES) begin
      for (int c = 0; c < FRAME_CYCLES; c++) begin
        if (tx_s[c] !== tx_s[(c / CLK_DIV) * CLK_DIV]) frame_ok = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
        if (tx_s[(10 * i) * CLK_DIV + 1] !== 1'b0) frame_ok = 1'b0;
        if (tx_s[(10 * i + 9) * CLK_DIV + 1] !== 1'b1) frame_ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          frame_bytes[72 - 8 * i + k] = tx_s[(10 * i + 1 + k) * CLK_DIV + 1];
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if (tx !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_tx: got %b expected 1", tx);
    end
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    n_compared++;
    if (frame_done !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done);
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    n_compared++;
    if (bad !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_quiet: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic check_frame(input string name, input logic [79:0] exp_bytes, input int exp_busy);
    n_compared++;
    if (frame_bytes !== exp_bytes) begin
      n_mismatched++;
      $display("[TB] FAIL %s_bytes: got %h expected %h", name, frame_bytes, exp_bytes);
    end
    n_compared++;
    if (frame_ok !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL %s_framing: got %b expected 1", name, frame_ok);
    end
    n_compared++;
    if (busy_cycles !== exp_busy) begin
      n_mismatched++;
      $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cycles, exp_busy);
    end
    n_compared++;
    if (done_pulses !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL %s_done_pulses: got %0d expected 1", name, done_pulses);
    end
  endtask

  task automatic test_basic_frame();
    total   = 32'h0000_0010;
    correct = 32'h0000_000F;
    pulse_report();
    collect(410, -1, 1'b0, '0, '0);
    check_frame("basic", {8'hA5, 32'h0000_0010, 32'h0000_000F, 8'h1F}, 400);
  endtask

  task automatic test_snapshot();
    total   = 32'h1234_5678;
    correct = 32'h1234_5670;
    pulse_report();
    collect(410, -1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    check_frame("snapshot", {8'hA5, 32'h1234_5678, 32'h1234_5670, 8'h08}, 400);
  endtask

  task automatic test_report_while_busy();
    total   = 32'h0000_0001;
    correct = 32'h0000_0001;
    pulse_report();
    collect(410, 100, 1'b0, '0, '0);
    check_frame("busy_retrigger", {8'hA5, 32'h0000_0001, 32'h0000_0001, 8'h00}, 400);
  endtask

  task automatic test_report_at_done();
    total   = 32'h0000_00AA;
    correct = 32'h0000_0055;
    pulse_report();
    collect(410, 400, 1'b0, '0, '0);
    check_frame("done_cycle_report", {8'hA5, 32'h0000_00AA, 32'h0000_0055, 8'hFF}, 400);
  endtask

  task automatic test_reset_mid_frame();
    total   = 32'h0000_0000;
    correct = 32'h0000_0001;
    pulse_report();
    collect(150, -1, 1'b0, '0, '0);
    n_compared++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mid_frame_line: got tx=%b busy=%b expected tx=0 busy=1", tx, busy);
    end
    rst = 1'b1;
    #1;
    n_compared++;
    if (tx !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL abort_tx: got %b expected 1", tx);
    end
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_busy: got %b expected 0", busy);
    end
    n_compared++;
    if (frame_done !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_frame_done: got %b expected 0", frame_done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_compared++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL no_resume: got busy=%b tx=%b expected busy=0 tx=1", busy, tx);
    end
    total   = 32'hDEAD_BEEF;
    correct = 32'hCAFE_F00D;
    pulse_report();
    collect(410, -1, 1'b0, '0, '0);
    check_frame("after_abort", {8'hA5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 8'hEB}, 400);
  endtask

  task automatic test_back_to_back();
    total   = 32'h0102_0304;
    correct = 32'h0506_0708;
    pulse_report();
    collect(401, -1, 1'b0, '0, '0);
    check_frame("b2b_first", {8'hA5, 32'h0102_0304, 32'h0506_0708, 8'h08}, 400);
    total   = 32'hFFFF_FFFF;
    correct = 32'h0000_0000;
    pulse_report();
    n_compared++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_accept: got busy=%b tx=%b expected busy=1 tx=0", busy, tx);
    end
    collect(410, -1, 1'b0, '0, '0);
    check_frame("b2b_second", {8'hA5, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00}, 400);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_snapshot();
    test_report_while_busy();
    test_report_at_done();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
